// File: rtl/uart_tx_param.sv
// uart_tx_param -- parametrised UART transmitter.
//
// Serialises a DATA_BITS payload (LSB first) with an optional parity bit and
// one or two stop bits. An internal divider holds each bit for CLKS_PER_BIT
// clocks. A one-entry holding buffer lets the host hand over the next word
// while a frame is still on the line, so that frames can run back to back
// without an idle gap.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   tx_data   payload, sampled at the handshake
//   tx_mode   parity select, sampled at the handshake
//             (00 none, 01 even, 10 odd, 11 none)
//   tx_valid  tx_data/tx_mode valid
//   tx_ready  holding buffer empty; handshake = tx_valid & tx_ready at a clk edge
//   TxD       serial line, idle high, registered
//   busy      a frame is in progress
//   tx_done   one-cycle pulse in the last cycle of the final stop bit
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           tx_mode,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TxD,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_PENULT = DIV_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q;
  logic [DIV_W-1:0]     div_q;
  logic [CNT_W-1:0]     cnt_q;       // data bit index, reused as stop bit index
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic [DATA_BITS-1:0] buf_data_q;
  logic [1:0]           buf_mode_q;
  logic                 buf_full_q;
  logic                 txd_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ready_q;

  logic hs;
  logic bit_end;
  logic last_stop_bit;
  logic stop_end;
  logic in_par_en;
  logic in_par_bit;
  logic buf_par_en;
  logic buf_par_bit;

  assign hs            = tx_valid && ready_q && !rst;
  assign bit_end       = (div_q == DIV_LAST);
  assign last_stop_bit = (state_q == S_STOP) && (cnt_q == STOP_LAST);
  assign stop_end      = last_stop_bit && bit_end;

  // Parity is only enabled for modes 01/10. Odd parity is the even parity
  // inverted, and mode[1] is set exactly for odd.
  assign in_par_en   = tx_mode[0] ^ tx_mode[1];
  assign in_par_bit  = (^tx_data) ^ tx_mode[1];
  assign buf_par_en  = buf_mode_q[0] ^ buf_mode_q[1];
  assign buf_par_bit = (^buf_data_q) ^ buf_mode_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      buf_data_q <= '0;
      buf_mode_q <= 2'b00;
      buf_full_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      // Registered pulse: raised one edge early so it is visible during the
      // last cycle of the final stop bit.
      done_q <= last_stop_bit && (div_q == DIV_PENULT);

      // A word offered while a frame is running parks in the buffer, except
      // on the frame's final edge where it is loaded straight into the shifter.
      if (hs && state_q != S_IDLE && !stop_end) begin
        buf_data_q <= tx_data;
        buf_mode_q <= tx_mode;
        buf_full_q <= 1'b1;
        ready_q    <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (hs) begin
            shift_q   <= tx_data;
            par_en_q  <= in_par_en;
            par_bit_q <= in_par_bit;
            div_q     <= '0;
            state_q   <= S_START;
            txd_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            div_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_DATA;
            txd_q   <= shift_q[0];
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            div_q <= '0;
            if (cnt_q == DATA_LAST) begin
              cnt_q <= '0;
              if (par_en_q) begin
                state_q <= S_PARITY;
                txd_q   <= par_bit_q;
              end else begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            div_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            div_q <= '0;
            if (cnt_q == STOP_LAST) begin
              cnt_q <= '0;
              if (buf_full_q) begin
                // Drain the buffer: next frame starts with no idle bit.
                shift_q    <= buf_data_q;
                par_en_q   <= buf_par_en;
                par_bit_q  <= buf_par_bit;
                buf_full_q <= 1'b0;
                ready_q    <= 1'b1;
                state_q    <= S_START;
                txd_q      <= 1'b0;
              end else if (hs) begin
                shift_q   <= tx_data;
                par_en_q  <= in_par_en;
                par_bit_q <= in_par_bit;
                state_q   <= S_START;
                txd_q     <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = ready_q;
  assign TxD      = txd_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed testbench for uart_tx_param.
// Instance A: CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1.
// Instance B: CLKS_PER_BIT=4, DATA_BITS=7, STOP_BITS=2.
// Outputs are sampled on the falling edge; cap_* index 0 is frame cycle 1.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, valid_a = 1'b0;
  logic [7:0] data_a = '0;
  logic [1:0] mode_a = '0;
  logic       ready_a, txd_a, busy_a, done_a;

  logic       rst_b = 1'b1, valid_b = 1'b0;
  logic [6:0] data_b = '0;
  logic [1:0] mode_b = '0;
  logic       ready_b, txd_b, busy_b, done_b;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst_a), .tx_data(data_a), .tx_mode(mode_a),
    .tx_valid(valid_a), .tx_ready(ready_a), .TxD(txd_a),
    .busy(busy_a), .tx_done(done_a)
  );

  uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst_b), .tx_data(data_b), .tx_mode(mode_b),
    .tx_valid(valid_b), .tx_ready(ready_b), .TxD(txd_b),
    .busy(busy_b), .tx_done(done_b)
  );

  int n_vec = 0;
  int n_err = 0;

  logic cap_txd   [0:127];
  logic cap_busy  [0:127];
  logic cap_done  [0:127];
  logic cap_ready [0:127];

  // Present one word for a single handshake edge; returns on the falling
  // edge just after the handshake (frame cycle 1).
  task automatic send_a(input logic [7:0] d, input logic [1:0] m);
    @(negedge clk);
    data_a = d; mode_a = m; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [6:0] d, input logic [1:0] m);
    @(negedge clk);
    data_b = d; mode_b = m; valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
  endtask

  task automatic capture_a(input int n);
    for (int i = 0; i < n; i++) begin
      cap_txd[i] = txd_a; cap_busy[i] = busy_a;
      cap_done[i] = done_a; cap_ready[i] = ready_a;
      @(negedge clk);
    end
  endtask

  task automatic capture_b(input int n);
    for (int i = 0; i < n; i++) begin
      cap_txd[i] = txd_b; cap_busy[i] = busy_b;
      cap_done[i] = done_b; cap_ready[i] = ready_b;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    n_vec++; if (txd_a !== 1'b1)   begin n_err++; $display("FAIL reset_txd_a got %b want 1", txd_a); end
    n_vec++; if (busy_a !== 1'b0)  begin n_err++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
    n_vec++; if (done_a !== 1'b0)  begin n_err++; $display("FAIL reset_done_a got %b want 0", done_a); end
    n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL reset_ready_a got %b want 1", ready_a); end
    n_vec++; if (txd_b !== 1'b1)   begin n_err++; $display("FAIL reset_txd_b got %b want 1", txd_b); end
    n_vec++; if (busy_b !== 1'b0)  begin n_err++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
    n_vec++; if (done_b !== 1'b0)  begin n_err++; $display("FAIL reset_done_b got %b want 0", done_b); end
    n_vec++; if (ready_b !== 1'b1) begin n_err++; $display("FAIL reset_ready_b got %b want 1", ready_b); end
    $display("reset: %0d vectors so far", n_vec);
  endtask

  // 0xA5, no parity: bit i of exp is frame bit i (start, d0..d7, stop).
  task automatic test_basic();
    logic [9:0] exp_bits;
    exp_bits = 10'b1101001010;
    send_a(8'hA5, 2'b00);
    capture_a(41);
    for (int k = 0; k < 40; k++) begin
      n_vec++;
      if (cap_txd[k] !== exp_bits[k/4]) begin
        n_err++; $display("FAIL basic_txd cycle %0d got %b want %b", k + 1, cap_txd[k], exp_bits[k/4]);
      end
    end
    n_vec++; if (cap_done[38] !== 1'b0) begin n_err++; $display("FAIL basic_done_c39 got %b want 0", cap_done[38]); end
    n_vec++; if (cap_done[39] !== 1'b1) begin n_err++; $display("FAIL basic_done_c40 got %b want 1", cap_done[39]); end
    n_vec++; if (cap_busy[39] !== 1'b1) begin n_err++; $display("FAIL basic_busy_c40 got %b want 1", cap_busy[39]); end
    n_vec++; if (cap_busy[40] !== 1'b0) begin n_err++; $display("FAIL basic_busy_c41 got %b want 0", cap_busy[40]); end
    n_vec++; if (cap_ready[20] !== 1'b1) begin n_err++; $display("FAIL basic_ready got %b want 1", cap_ready[20]); end
    $display("basic 0xA5 mode 00: %0d vectors so far", n_vec);
  endtask

  // 0xA5 has four ones: even parity bit 0, odd parity bit 1, 44-cycle frames.
  task automatic test_parity();
    logic [10:0] exp_even, exp_odd;
    exp_even = 11'b10101001010;
    exp_odd  = 11'b11101001010;
    send_a(8'hA5, 2'b01);
    capture_a(45);
    for (int k = 0; k < 44; k++) begin
      n_vec++;
      if (cap_txd[k] !== exp_even[k/4]) begin
        n_err++; $display("FAIL even_txd cycle %0d got %b want %b", k + 1, cap_txd[k], exp_even[k/4]);
      end
    end
    n_vec++; if (cap_done[43] !== 1'b1) begin n_err++; $display("FAIL even_done_c44 got %b want 1", cap_done[43]); end
    n_vec++; if (cap_busy[44] !== 1'b0) begin n_err++; $display("FAIL even_busy_c45 got %b want 0", cap_busy[44]); end
    $display("parity even: %0d vectors so far", n_vec);

    send_a(8'hA5, 2'b10);
    mode_a = 2'b00;  // change after the handshake must not alter the frame
    capture_a(45);
    for (int k = 0; k < 44; k++) begin
      n_vec++;
      if (cap_txd[k] !== exp_odd[k/4]) begin
        n_err++; $display("FAIL odd_txd cycle %0d got %b want %b", k + 1, cap_txd[k], exp_odd[k/4]);
      end
    end
    n_vec++; if (cap_done[43] !== 1'b1) begin n_err++; $display("FAIL odd_done_c44 got %b want 1", cap_done[43]); end
    n_vec++; if (cap_busy[44] !== 1'b0) begin n_err++; $display("FAIL odd_busy_c45 got %b want 0", cap_busy[44]); end
    $display("parity odd: %0d vectors so far", n_vec);
  endtask

  // 0x3C accepted at once, 0xC3 buffered; frames abut with no idle bit.
  task automatic test_back_to_back();
    logic [19:0] exp_bits;
    int bad_ready, bad_busy;
    exp_bits = 20'b1110000110_1001111000;
    bad_ready = -1; bad_busy = -1;
    @(negedge clk);
    data_a = 8'h3C; mode_a = 2'b00; valid_a = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 81; k++) begin
      cap_txd[k] = txd_a; cap_busy[k] = busy_a;
      cap_done[k] = done_a; cap_ready[k] = ready_a;
      if (k == 0) data_a = 8'hC3;
      if (k == 1) valid_a = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 80; k++) begin
      n_vec++;
      if (cap_txd[k] !== exp_bits[k/4]) begin
        n_err++; $display("FAIL b2b_txd cycle %0d got %b want %b", k + 1, cap_txd[k], exp_bits[k/4]);
      end
      if (cap_busy[k] !== 1'b1 && bad_busy < 0) bad_busy = k;
      if (k >= 1 && k < 40 && cap_ready[k] !== 1'b0 && bad_ready < 0) bad_ready = k;
    end
    n_vec++; if (bad_busy >= 0) begin n_err++; $display("FAIL b2b_busy cycle %0d got 0 want 1", bad_busy + 1); end
    n_vec++; if (bad_ready >= 0) begin n_err++; $display("FAIL b2b_ready_low cycle %0d got 1 want 0", bad_ready + 1); end
    n_vec++; if (cap_ready[0] !== 1'b1)  begin n_err++; $display("FAIL b2b_ready_c1 got %b want 1", cap_ready[0]); end
    n_vec++; if (cap_ready[40] !== 1'b1) begin n_err++; $display("FAIL b2b_ready_c41 got %b want 1", cap_ready[40]); end
    n_vec++; if (cap_done[39] !== 1'b1)  begin n_err++; $display("FAIL b2b_done1 got %b want 1", cap_done[39]); end
    n_vec++; if (cap_done[79] !== 1'b1)  begin n_err++; $display("FAIL b2b_done2 got %b want 1", cap_done[79]); end
    n_vec++; if (cap_busy[80] !== 1'b0)  begin n_err++; $display("FAIL b2b_busy_end got %b want 0", cap_busy[80]); end
    n_vec++; if (cap_txd[80] !== 1'b1)   begin n_err++; $display("FAIL b2b_txd_end got %b want 1", cap_txd[80]); end
    $display("back_to_back 0x3C,0xC3: %0d vectors so far", n_vec);
  endtask

  // Instance B: 7 data bits, two stop bits -> 40-cycle frame, 8-cycle stop.
  task automatic test_two_stop();
    logic [9:0] exp_55, exp_7f;
    exp_55 = 10'b1110101010;
    exp_7f = 10'b1111111110;
    send_b(7'h55, 2'b00);
    capture_b(41);
    for (int k = 0; k < 40; k++) begin
      n_vec++;
      if (cap_txd[k] !== exp_55[k/4]) begin
        n_err++; $display("FAIL stop2_55_txd cycle %0d got %b want %b", k + 1, cap_txd[k], exp_55[k/4]);
      end
    end
    n_vec++; if (cap_done[35] !== 1'b0) begin n_err++; $display("FAIL stop2_done_first_stop got %b want 0", cap_done[35]); end
    n_vec++; if (cap_done[39] !== 1'b1) begin n_err++; $display("FAIL stop2_done_c40 got %b want 1", cap_done[39]); end
    n_vec++; if (cap_busy[40] !== 1'b0) begin n_err++; $display("FAIL stop2_busy_c41 got %b want 0", cap_busy[40]); end
    $display("two_stop 0x55: %0d vectors so far", n_vec);

    send_b(7'h7F, 2'b00);  // 0xFF reduced to the 7-bit payload width
    capture_b(41);
    for (int k = 0; k < 40; k++) begin
      n_vec++;
      if (cap_txd[k] !== exp_7f[k/4]) begin
        n_err++; $display("FAIL stop2_7f_txd cycle %0d got %b want %b", k + 1, cap_txd[k], exp_7f[k/4]);
      end
    end
    n_vec++; if (cap_busy[40] !== 1'b0) begin n_err++; $display("FAIL stop2_7f_busy got %b want 0", cap_busy[40]); end
    $display("two_stop 0x7F: %0d vectors so far", n_vec);
  endtask

  // Reset in the middle of DATA with a word buffered, then a clean resend.
  task automatic test_mid_reset();
    logic [9:0] exp_01;
    int bad_idle;
    exp_01 = 10'b1000000010;
    bad_idle = -1;
    @(negedge clk);
    data_a = 8'h81; mode_a = 2'b00; valid_a = 1'b1;
    @(negedge clk);
    data_a = 8'h42;
    @(negedge clk);
    valid_a = 1'b0;
    n_vec++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL mrst_buffered_ready got %b want 0", ready_a); end
    repeat (16) @(negedge clk);
    rst_a = 1'b1; valid_a = 1'b1; data_a = 8'hEE;  // valid during rst is ignored
    @(negedge clk);
    rst_a = 1'b0; valid_a = 1'b0;
    n_vec++; if (txd_a !== 1'b1)   begin n_err++; $display("FAIL mrst_txd got %b want 1", txd_a); end
    n_vec++; if (busy_a !== 1'b0)  begin n_err++; $display("FAIL mrst_busy got %b want 0", busy_a); end
    n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL mrst_ready got %b want 1", ready_a); end
    n_vec++; if (done_a !== 1'b0)  begin n_err++; $display("FAIL mrst_done got %b want 0", done_a); end
    for (int k = 0; k < 60; k++) begin
      if ((txd_a !== 1'b1 || busy_a !== 1'b0) && bad_idle < 0) bad_idle = k;
      @(negedge clk);
    end
    n_vec++; if (bad_idle >= 0) begin n_err++; $display("FAIL mrst_idle cycle %0d got activity want idle", bad_idle); end
    send_a(8'h01, 2'b00);
    capture_a(41);
    for (int k = 0; k < 40; k++) begin
      n_vec++;
      if (cap_txd[k] !== exp_01[k/4]) begin
        n_err++; $display("FAIL mrst_01_txd cycle %0d got %b want %b", k + 1, cap_txd[k], exp_01[k/4]);
      end
    end
    n_vec++; if (cap_done[39] !== 1'b1) begin n_err++; $display("FAIL mrst_01_done got %b want 1", cap_done[39]); end
    n_vec++; if (cap_busy[40] !== 1'b0) begin n_err++; $display("FAIL mrst_01_busy got %b want 0", cap_busy[40]); end
    $display("mid_reset then 0x01: %0d vectors so far", n_vec);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_two_stop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d vectors", n_vec);
    $fatal(1, "timeout");
  end

endmodule
